// File: rtl/solo_squash_inputs_pkg.sv
// Shared solo_squash constants: debounce defaults next to the game timing values,
// plus the button channel ordering used by the input conditioner.
package solo_squash_inputs_pkg;

    localparam int TICK_DIV_DEFAULT       = 25000;
    localparam int DEBOUNCE_TICKS_DEFAULT = 5;
    localparam int SYNC_STAGES_DEFAULT    = 2;

    localparam int H_VISIBLE     = 640;
    localparam int V_VISIBLE     = 480;
    localparam int PADDLE_HEIGHT = 64;

    localparam int NUM_CHANNELS = 4;

    typedef enum logic [1:0] {
        CH_PAUSE    = 2'd0,
        CH_NEW_GAME = 2'd1,
        CH_UP       = 2'd2,
        CH_DOWN     = 2'd3
    } chan_e;

    // Width of a counter that must hold 0..n-1; never narrower than one bit.
    function automatic int count_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/solo_squash_debounce.sv
// One button channel: synchroniser chain, tick-based debounce counter, committed
// stable level and a single-cycle strobe when a press commits.
module solo_squash_debounce
    import solo_squash_inputs_pkg::*;
#(
    parameter int SYNC_STAGES    = SYNC_STAGES_DEFAULT,
    parameter int DEBOUNCE_TICKS = DEBOUNCE_TICKS_DEFAULT
) (
    input  logic clk,
    input  logic reset_n,
    input  logic tick,
    input  logic raw_n,
    output logic stable,
    output logic fall
);

    localparam int                CNT_W    = count_width(DEBOUNCE_TICKS);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_TICKS - 1);

    logic [SYNC_STAGES-1:0] sync_reg;
    logic [CNT_W-1:0]       cnt_reg;
    logic                   stable_reg;
    logic                   synced;
    logic                   commit;

    assign synced = sync_reg[SYNC_STAGES-1];
    assign commit = tick && (synced != stable_reg) && (cnt_reg == CNT_LAST);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_reg <= '1;
        end else begin
            sync_reg <= {sync_reg[SYNC_STAGES-2:0], raw_n};
        end
    end

    // Any cycle of agreement throws away the partial count.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_reg    <= '0;
            stable_reg <= 1'b1;
        end else if (synced == stable_reg) begin
            cnt_reg <= '0;
        end else if (commit) begin
            cnt_reg    <= '0;
            stable_reg <= synced;
        end else if (tick) begin
            cnt_reg <= cnt_reg + CNT_W'(1);
        end
    end

    assign stable = stable_reg;
    assign fall   = commit && !synced;

endmodule

// File: rtl/solo_squash_inputs.sv
// Conditions the four raw active-low buttons into synchronised, debounced game
// inputs: shared debounce prescaler, new-game strobe and pause toggle.
module solo_squash_inputs
    import solo_squash_inputs_pkg::*;
#(
    parameter int TICK_DIV       = TICK_DIV_DEFAULT,
    parameter int DEBOUNCE_TICKS = DEBOUNCE_TICKS_DEFAULT,
    parameter int SYNC_STAGES    = SYNC_STAGES_DEFAULT,
    parameter int PAUSE_TOGGLE   = 1
) (
    input  logic clk,
    input  logic reset_n,
    input  logic pause_raw_n,
    input  logic new_game_raw_n,
    input  logic up_raw_n,
    input  logic down_raw_n,
    output logic pause_n,
    output logic new_game_n,
    output logic up_key_n,
    output logic down_key_n
);

    localparam int                PRE_W    = count_width(TICK_DIV);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

    logic [PRE_W-1:0]        prescale_reg;
    logic                    tick;
    logic [NUM_CHANNELS-1:0] raw_vec;
    logic [NUM_CHANNELS-1:0] stable_vec;
    logic [NUM_CHANNELS-1:0] fall_vec;
    logic                    new_game_reg;

    assign raw_vec = {down_raw_n, up_raw_n, new_game_raw_n, pause_raw_n};
    assign tick    = (prescale_reg == PRE_LAST);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prescale_reg <= '0;
        end else if (tick) begin
            prescale_reg <= '0;
        end else begin
            prescale_reg <= prescale_reg + PRE_W'(1);
        end
    end

    for (genvar gi = 0; gi < NUM_CHANNELS; gi++) begin : g_chan
        solo_squash_debounce #(
            .SYNC_STAGES    (SYNC_STAGES),
            .DEBOUNCE_TICKS (DEBOUNCE_TICKS)
        ) u_debounce (
            .clk     (clk),
            .reset_n (reset_n),
            .tick    (tick),
            .raw_n   (raw_vec[gi]),
            .stable  (stable_vec[gi]),
            .fall    (fall_vec[gi])
        );
    end

    // Strobe lands on the same edge the new-game level commits low.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            new_game_reg <= 1'b1;
        end else begin
            new_game_reg <= !fall_vec[CH_NEW_GAME];
        end
    end

    if (PAUSE_TOGGLE != 0) begin : g_pause_toggle
        logic paused_reg;
        logic unused_fall;

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                paused_reg <= 1'b0;
            end else if (fall_vec[CH_PAUSE]) begin
                paused_reg <= !paused_reg;
            end
        end

        assign pause_n     = !paused_reg;
        assign unused_fall = ^{fall_vec[CH_DOWN], fall_vec[CH_UP], stable_vec[CH_PAUSE]};
    end else begin : g_pause_level
        logic unused_fall;

        assign pause_n     = stable_vec[CH_PAUSE];
        assign unused_fall = ^{fall_vec[CH_DOWN], fall_vec[CH_UP], fall_vec[CH_PAUSE]};
    end

    assign new_game_n = new_game_reg;
    assign up_key_n   = stable_vec[CH_UP];
    assign down_key_n = stable_vec[CH_DOWN];

endmodule

// File: tb/tb_solo_squash_inputs.sv
// Randomised and directed stimulus for solo_squash_inputs, checked every cycle
// against a behavioural model of the button-conditioning rules.
module tb_solo_squash_inputs;

    localparam int TICK_DIV       = 4;
    localparam int DEBOUNCE_TICKS = 3;
    localparam int SYNC_STAGES    = 2;
    localparam int NCH            = 4;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [3:0] raw;
    logic       pause_n, new_game_n, up_key_n, down_key_n;
    wire  [3:0] outs = {down_key_n, up_key_n, new_game_n, pause_n};

    int vectors     = 0;
    int miscompares = 0;
    bit cmp_en      = 1'b0;

    // Behavioural model state
    int phase_m = 0;
    int hist_m[NCH][SYNC_STAGES];
    int stable_m[NCH];
    int ticks_in_run_m[NCH];
    bit paused_m = 1'b0;
    bit new_game_m = 1'b1;

    solo_squash_inputs #(
        .TICK_DIV       (TICK_DIV),
        .DEBOUNCE_TICKS (DEBOUNCE_TICKS),
        .SYNC_STAGES    (SYNC_STAGES),
        .PAUSE_TOGGLE   (1)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .pause_raw_n    (raw[0]),
        .new_game_raw_n (raw[1]),
        .up_raw_n       (raw[2]),
        .down_raw_n     (raw[3]),
        .pause_n        (pause_n),
        .new_game_n     (new_game_n),
        .up_key_n       (up_key_n),
        .down_key_n     (down_key_n)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        phase_m    = 0;
        paused_m   = 1'b0;
        new_game_m = 1'b1;
        for (int c = 0; c < NCH; c++) begin
            stable_m[c]       = 1;
            ticks_in_run_m[c] = 0;
            for (int s = 0; s < SYNC_STAGES; s++) hist_m[c][s] = 1;
        end
    endtask

    // A level commits once the synchronised input has disagreed with the committed
    // level without a break for DEBOUNCE_TICKS tick instants.
    task automatic model_step();
        bit tick_now;
        bit strobe;
        int seen;
        tick_now = (phase_m == TICK_DIV - 1);
        strobe   = 1'b0;
        for (int c = 0; c < NCH; c++) begin
            seen = hist_m[c][SYNC_STAGES-1];
            if (seen == stable_m[c]) begin
                ticks_in_run_m[c] = 0;
            end else if (tick_now) begin
                ticks_in_run_m[c] = ticks_in_run_m[c] + 1;
                if (ticks_in_run_m[c] == DEBOUNCE_TICKS) begin
                    stable_m[c]       = seen;
                    ticks_in_run_m[c] = 0;
                    if (seen == 0 && c == 0) paused_m = !paused_m;
                    if (seen == 0 && c == 1) strobe = 1'b1;
                end
            end
            for (int s = SYNC_STAGES - 1; s > 0; s--) hist_m[c][s] = hist_m[c][s-1];
            hist_m[c][0] = int'(raw[c]);
        end
        new_game_m = !strobe;
        phase_m    = (phase_m + 1) % TICK_DIV;
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge reset_n);
            if (!reset_n) model_reset();
            else model_step();
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            check("cyc_pause_n",    int'(pause_n),    paused_m ? 0 : 1);
            check("cyc_new_game_n", int'(new_game_n), int'(new_game_m));
            check("cyc_up_key_n",   int'(up_key_n),   stable_m[2]);
            check("cyc_down_key_n", int'(down_key_n), stable_m[3]);
        end
    end

    // Observe one output bit for n cycles: first change, number of changes, low cycles.
    task automatic watch(input int ch, input int n, output int first,
                         output int changes, output int zeros);
        logic [3:0] o;
        logic       prev;
        o = outs;
        prev = o[ch];
        first = -1;
        changes = 0;
        zeros = 0;
        for (int i = 1; i <= n; i++) begin
            @(negedge clk);
            o = outs;
            if (o[ch] !== prev) begin
                changes++;
                if (first < 0) first = i;
            end
            if (o[ch] === 1'b0) zeros++;
            prev = o[ch];
        end
    endtask

    initial begin
        int f, c, z, f2, c2, z2, a;
        raw = 4'hF;
        reset_n = 1'b0;
        @(negedge clk);
        cmp_en = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_pause_n", int'(pause_n), 1);
        check("rst_new_game_n", int'(new_game_n), 1);
        check("rst_up_key_n", int'(up_key_n), 1);
        check("rst_down_key_n", int'(down_key_n), 1);
        #1 reset_n = 1'b1;
        @(negedge clk);
        check("post_rst_outs", int'(outs), 15);
        $display("reset: outs=%b", outs);

        repeat ($urandom_range(0, 7)) @(negedge clk);
        raw[3] = 1'b0;
        watch(3, 30, f, c, z);
        check("down_latency_11_14", int'(f >= 11 && f <= 14), 1);
        check("down_single_fall", c, 1);
        watch(3, 20, f2, c2, z2);
        check("down_stays_low", z2, 20);
        $display("down press: latency=%0d changes=%0d", f, c);

        raw[2] = 1'b0;
        watch(2, 6, f, c, z);
        raw[2] = 1'b1;
        watch(2, 30, f2, c2, z2);
        check("up_glitch_ignored", z + z2, 0);
        $display("up 6-cycle glitch: low cycles=%0d", z + z2);

        raw[1] = 1'b0;
        watch(1, 200, f, c, z);
        raw[1] = 1'b1;
        watch(1, 40, f2, c2, z2);
        check("ng_strobe_once", z, 1);
        check("ng_strobe_latency", int'(f >= 11 && f <= 14), 1);
        check("ng_no_release_strobe", z2, 0);
        $display("new game hold: strobe cycles=%0d latency=%0d after release=%0d", z, f, z2);

        check("pause_idle", int'(pause_n), 1);
        for (int p = 0; p < 2; p++) begin
            raw[0] = 1'b0;
            watch(0, 40, f, c, z);
            check("pause_press_latency", int'(f >= 11 && f <= 14), 1);
            check("pause_press_level", int'(pause_n), (p == 0) ? 0 : 1);
            raw[0] = 1'b1;
            watch(0, 40, f2, c2, z2);
            check("pause_release_ignored", c2, 0);
            $display("pause press %0d: latency=%0d pause_n=%b", p, f, pause_n);
        end

        check("down_before_reset", int'(down_key_n), 0);
        @(negedge clk);
        #1 reset_n = 1'b0;
        #1 check("async_reset_outs", int'(outs), 15);
        @(negedge clk);
        #1 reset_n = 1'b1;
        repeat (7) @(negedge clk);
        check("down_mid_count", int'(down_key_n), 1);
        #1 reset_n = 1'b0;
        @(negedge clk);
        #1 reset_n = 1'b1;
        watch(3, 30, f, c, z);
        check("down_relatch_latency", int'(f >= 11 && f <= 14), 1);
        $display("reset mid-count: relatch latency=%0d", f);

        for (int it = 0; it < 200; it++) begin
            int ch, val, hold;
            bit do_rst;
            ch = $urandom_range(0, 3);
            val = $urandom_range(0, 1);
            hold = $urandom_range(1, 30);
            do_rst = ($urandom_range(0, 29) == 0);
            if (do_rst) begin
                #1 reset_n = 1'b0;
                @(negedge clk);
                #1 reset_n = 1'b1;
            end
            raw[ch] = val[0];
            repeat (hold) @(negedge clk);
            $display("rand %0d: ch=%0d val=%0d hold=%0d rst=%0d outs=%b", it, ch, val, hold, do_rst, outs);
        end

        raw = 4'hF;
        repeat (40) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

endmodule
